// File: rtl/result_access_pkg.sv
// result_access_pkg
//   Shared definitions for the result_access block and its holding buffer:
//   default widths, the control state encoding and the holding-buffer
//   geometry, plus a small pointer-advance helper.
package result_access_pkg;

  // Default widths for the top-level parameters.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 11;

  // Holding buffer geometry: two entries is enough to cover the one-cycle
  // RAM read latency while still sustaining one word per cycle.
  localparam int BUF_DEPTH = 2;
  localparam int BUF_PTR_W = 1;
  localparam int BUF_OCC_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_e;

  // Advance a circular holding-buffer pointer.
  function automatic logic [BUF_PTR_W-1:0] next_ptr(input logic [BUF_PTR_W-1:0] p);
    logic [BUF_PTR_W-1:0] n;
    if (p == BUF_PTR_W'(BUF_DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + BUF_PTR_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/result_skid_buf.sv
// result_skid_buf
//   Two-entry FIFO-ordered holding buffer sitting between the result RAM read
//   port and the output FIFO write port.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         discard all held words (used when a transfer is aborted)
//   push          capture push_data at the tail
//   push_data     word to capture
//   pop           remove the head word (caller guarantees head_valid)
//   head          oldest held word
//   head_valid    buffer is not empty
//   occ           number of held words (0..2)
//
// A push and a pop in the same cycle leave the occupancy unchanged and keep
// the words in order.
module result_skid_buf
  import result_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic [DATA_W-1:0]    push_data,
  input  logic                 pop,
  output logic [DATA_W-1:0]    head,
  output logic                 head_valid,
  output logic [BUF_OCC_W-1:0] occ
);

  logic [DATA_W-1:0]    mem_q [BUF_DEPTH];
  logic [DATA_W-1:0]    mem_d [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      // Stored data is left in place; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + BUF_OCC_W'(1);
        2'b01:   occ_d = occ_q - BUF_OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (occ_q != '0);
  assign occ        = occ_q;

endmodule

// File: rtl/result_access.sv
// result_access
//   Streams cfg_len words out of the result buffer (synchronous RAM, one-cycle
//   read latency) starting at cfg_base_addr and pushes them into the write side
//   of the output FIFO, honouring its full flag. Runs while the control FSM
//   holds ResultRd_en high and answers with a one-cycle OutputRd_done once the
//   last word has been pushed.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ResultRd_en     level request from the control FSM (dropping it aborts)
//   cfg_base_addr   first buffer address, sampled when a transfer starts
//   cfg_len         word count, sampled when a transfer starts
//   rbuf_rd_en      result buffer read strobe
//   rbuf_addr       result buffer read address (wraps modulo 2^ADDR_W)
//   rbuf_rdata      read data, valid the cycle after rbuf_rd_en
//   txfifo_wr_en    output FIFO push
//   txfifo_wdata    output FIFO push data
//   txfifo_full     output FIFO full; no push while high
//   OutputRd_done   one-cycle completion pulse
//   busy            high whenever the block is not idle
//
// Build option:
//   RESULT_ACCESS_SUM_EN  when defined, a running sum (modulo 2^DATA_W) of the
//                         pushed data words is appended as one extra checksum
//                         word after the last data word.
module result_access
  import result_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ResultRd_en,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              rbuf_rd_en,
  output logic [ADDR_W-1:0] rbuf_addr,
  input  logic [DATA_W-1:0] rbuf_rdata,
  output logic              txfifo_wr_en,
  output logic [DATA_W-1:0] txfifo_wdata,
  input  logic              txfifo_full,
  output logic              OutputRd_done,
  output logic              busy
);

  localparam int LVL_W = BUF_OCC_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(BUF_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              in_flight_q, in_flight_d;

  logic                 run_active;
  logic                 buf_flush;
  logic                 pop;
  logic                 rd_issue;
  logic [LVL_W-1:0]     level;
  logic [DATA_W-1:0]    head;
  logic                 head_valid;
  logic [BUF_OCC_W-1:0] occ;

`ifdef RESULT_ACCESS_SUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              sum_push;
`endif

  // The word read last cycle arrives now; it is captured unless the transfer
  // is being aborted, in which case flush wins inside the buffer.
  result_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (buf_flush),
    .push       (in_flight_q),
    .push_data  (rbuf_rdata),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .occ        (occ)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      in_flight_q <= 1'b0;
`ifdef RESULT_ACCESS_SUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      in_flight_q <= in_flight_d;
`ifdef RESULT_ACCESS_SUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Output / handshake logic.
  always_comb begin
    // Once the FSM drops its request nothing more is read or pushed; the
    // cycle is spent discarding held data on the way back to IDLE.
    run_active = (state_q == RUN) && ResultRd_en;
    buf_flush  = (state_q == RUN) && !ResultRd_en;
    pop        = run_active && head_valid && !txfifo_full;

    // Words that will be held after this cycle if no new read is issued.
    // Keeping it below the buffer depth guarantees room for the next capture.
    level    = LVL_W'(occ) + LVL_W'(in_flight_q) - LVL_W'(pop);
    rd_issue = run_active && (rd_cnt_q < len_q) && (level < DEPTH_LVL);

    rbuf_rd_en    = rd_issue;
    rbuf_addr     = base_q + rd_cnt_q[ADDR_W-1:0];
    OutputRd_done = (state_q == DONE);
    busy          = (state_q != IDLE);

`ifdef RESULT_ACCESS_SUM_EN
    // All data words are out (so the buffer is empty): send the checksum.
    sum_push     = run_active && (wr_cnt_q == len_q) && !txfifo_full;
    txfifo_wr_en = pop || sum_push;
    txfifo_wdata = sum_push ? sum_q : head;
`else
    txfifo_wr_en = pop;
    txfifo_wdata = head;
`endif
  end

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_q + LEN_W'(rd_issue);
    wr_cnt_d    = wr_cnt_q + LEN_W'(pop);
    in_flight_d = rd_issue;
`ifdef RESULT_ACCESS_SUM_EN
    sum_d       = pop ? (sum_q + head) : sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (ResultRd_en) begin
          base_d   = cfg_base_addr;
          len_d    = cfg_len;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
`ifdef RESULT_ACCESS_SUM_EN
          sum_d    = '0;
          // Even an empty transfer has a checksum word to push.
          state_d  = RUN;
`else
          state_d  = (cfg_len == '0) ? DONE : RUN;
`endif
        end
      end

      RUN: begin
        if (!ResultRd_en) begin
          state_d = IDLE;
`ifdef RESULT_ACCESS_SUM_EN
        end else if (sum_push) begin
          state_d = DONE;
`else
        end else if (wr_cnt_d == len_q) begin
          // Leave on the cycle of the last push so the pulse follows directly.
          state_d = DONE;
`endif
        end
      end

      DONE: begin
        state_d = REARM;
      end

      REARM: begin
        // The FSM still holds its request during the done cycle; wait for it
        // to drop so the same request does not start a second transfer.
        if (!ResultRd_en) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_result_access.sv
// tb_result_access
//   Self-checking bench for result_access. The bench acts as the result RAM
//   and drives the FIFO full flag; each transfer's expectations (address
//   sequence, pushed word sequence, checksum, pulse timing) come from the
//   buffer contents and simple arithmetic.
//   Define RESULT_ACCESS_SUM_EN for both bench and RTL to cover the checksum.
module tb_result_access;

  logic        clk;
  logic        rst_n;
  logic        ResultRd_en;
  logic [9:0]  cfg_base_addr;
  logic [10:0] cfg_len;
  logic        rbuf_rd_en;
  logic [9:0]  rbuf_addr;
  logic [31:0] rbuf_rdata;
  logic        txfifo_wr_en;
  logic [31:0] txfifo_wdata;
  logic        txfifo_full;
  logic        OutputRd_done;
  logic        busy;

  logic [31:0] mem [1024];
  logic [31:0] lastWdata;
  int          errCount;
  int          checkCount;

  result_access u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ResultRd_en   (ResultRd_en),
    .cfg_base_addr (cfg_base_addr),
    .cfg_len       (cfg_len),
    .rbuf_rd_en    (rbuf_rd_en),
    .rbuf_addr     (rbuf_addr),
    .rbuf_rdata    (rbuf_rdata),
    .txfifo_wr_en  (txfifo_wr_en),
    .txfifo_wdata  (txfifo_wdata),
    .txfifo_full   (txfifo_full),
    .OutputRd_done (OutputRd_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result buffer: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rbuf_rd_en) begin
      rbuf_rdata <= mem[rbuf_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic fillMem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
    end
  endtask

  // Cycle (counted from the request cycle c0) of the k-th push with no
  // backpressure: data word k goes out at c(k+3); the checksum follows the
  // last data word, or goes out at c1 for an empty transfer.
  function automatic int expPushCyc(input int k, input int len);
    if (k < len) return k + 3;
    return (len > 0) ? len + 3 : 1;
  endfunction

  // Runs one request starting at the current cycle (entered just after a
  // rising edge). fullMode: 0 never full, 1 full on cycles fullLo..fullHi,
  // 2 random. abortAt >= 0 drops the request on that cycle. hold = extra
  // cycles the request stays high after the done pulse.
  task automatic applyStimulus(input logic [9:0] base, input int len,
                               input int fullMode, input int fullLo,
                               input int fullHi, input int abortAt,
                               input int hold);
    logic [31:0] expQ[$];
    logic [31:0] sum;
    int nExp, expDone, reads, pushes, dones, releaseCyc, budget;
    bit finished;

    sum = '0;
    for (int i = 0; i < len; i++) begin
      expQ.push_back(mem[(int'(base) + i) % 1024]);
      sum = sum + mem[(int'(base) + i) % 1024];
    end
`ifdef RESULT_ACCESS_SUM_EN
    expQ.push_back(sum);
`endif
    nExp       = expQ.size();
    expDone    = (nExp == 0) ? 1 : expPushCyc(nExp - 1, len) + 1;
    reads      = 0;
    pushes     = 0;
    dones      = 0;
    releaseCyc = -1;
    finished   = 1'b0;
    budget     = 60 + 4 * len;

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (abortAt >= 0) begin
        ResultRd_en = (cyc < abortAt);
      end else begin
        ResultRd_en = (releaseCyc < 0) || (cyc < releaseCyc);
      end
      // Configuration is only meaningful on the request cycle.
      cfg_base_addr = (cyc == 0) ? base : 10'($urandom);
      cfg_len       = (cyc == 0) ? 11'(len) : 11'($urandom);
      case (fullMode)
        1:       txfifo_full = (cyc >= fullLo) && (cyc <= fullHi);
        2:       txfifo_full = ($urandom_range(0, 2) == 0);
        default: txfifo_full = 1'b0;
      endcase

      @(negedge clk);
      if (txfifo_wr_en) begin
        checkOutput("push_while_full", 32'(txfifo_full), 32'd0);
        if (pushes < nExp) begin
          checkOutput("push_data", txfifo_wdata, expQ[pushes]);
          if (fullMode == 0 && abortAt < 0) begin
            checkOutput("push_cycle", cyc, expPushCyc(pushes, len));
          end
        end else begin
          checkOutput("extra_push", pushes + 1, nExp);
        end
        if (abortAt >= 0) begin
          checkOutput("push_after_abort", 32'(cyc > abortAt), 32'd0);
        end
        lastWdata = txfifo_wdata;
        pushes++;
      end
      if (rbuf_rd_en) begin
        checkOutput("rd_addr", 32'(rbuf_addr), (int'(base) + reads) % 1024);
        if (fullMode == 0 && abortAt < 0) begin
          checkOutput("rd_cycle", cyc, reads + 1);
        end
        reads++;
        checkOutput("rd_ahead", 32'((reads - pushes) <= 2), 32'd1);
      end
      if (OutputRd_done) begin
        dones++;
        if (dones == 1) begin
          if (fullMode == 0) begin
            checkOutput("done_cycle", cyc, expDone);
          end
          releaseCyc = cyc + hold + 1;
        end
      end
      if (abortAt >= 0 && cyc == abortAt + 1) begin
        checkOutput("abort_idle", 32'(busy), 32'd0);
      end
      if (abortAt >= 0 && cyc == abortAt + 6) begin
        finished = 1'b1;
      end
      if (abortAt < 0 && releaseCyc >= 0 && cyc == releaseCyc) begin
        checkOutput("busy_rearm", 32'(busy), 32'd1);
      end
      if (abortAt < 0 && releaseCyc >= 0 && cyc == releaseCyc + 1) begin
        checkOutput("busy_idle", 32'(busy), 32'd0);
        finished = 1'b1;
      end
      @(posedge clk);
      #1;
      if (finished) break;
    end

    checkOutput("finished", 32'(finished), 32'd1);
    if (abortAt < 0) begin
      checkOutput("reads_total", reads, len);
      checkOutput("push_total", pushes, nExp);
      checkOutput("done_count", dones, 1);
    end else begin
      checkOutput("abort_no_done", dones, 0);
    end
    ResultRd_en = 1'b0;
    txfifo_full = 1'b0;
  endtask

  initial begin
    errCount      = 0;
    checkCount    = 0;
    lastWdata     = '0;
    rst_n         = 1'b0;
    ResultRd_en   = 1'b0;
    cfg_base_addr = '0;
    cfg_len       = '0;
    txfifo_full   = 1'b0;
    fillMem();

    #12;
    checkOutput("rst_rd_en", 32'(rbuf_rd_en), 32'd0);
    checkOutput("rst_addr", 32'(rbuf_addr), 32'd0);
    checkOutput("rst_wr_en", 32'(txfifo_wr_en), 32'd0);
    checkOutput("rst_wdata", txfifo_wdata, 32'd0);
    checkOutput("rst_done", 32'(OutputRd_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic len=4");
    applyStimulus(10'h010, 4, 0, 0, 0, -1, 1);
    $display("[TB] backpressure len=8");
    applyStimulus(10'h020, 8, 1, 4, 9, -1, 0);
    $display("[TB] wrap-around");
    applyStimulus(10'h3FE, 4, 0, 0, 0, -1, 0);
    $display("[TB] zero length");
    applyStimulus(10'h050, 0, 0, 0, 0, -1, 4);
    $display("[TB] abort then restart");
    fillMem();
    applyStimulus(10'h080, 8, 0, 0, 0, 3, 0);
    applyStimulus(10'h200, 5, 0, 0, 0, -1, 0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 8; t++) begin
      fillMem();
      applyStimulus(10'($urandom), $urandom_range(1, 24), 2, 0, 0, -1,
                    $urandom_range(0, 3));
    end

    $display("[TB] reset mid-transfer");
    cfg_base_addr = 10'h040;
    cfg_len       = 11'd8;
    ResultRd_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rd_en", 32'(rbuf_rd_en), 32'd0);
    checkOutput("midrst_wr_en", 32'(txfifo_wr_en), 32'd0);
    ResultRd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(10'h100, 6, 0, 0, 0, -1, 0);

`ifdef RESULT_ACCESS_SUM_EN
    $display("[TB] checksum");
    mem[10'h300] = 32'd1;
    mem[10'h301] = 32'd2;
    mem[10'h302] = 32'd3;
    mem[10'h303] = 32'hFFFF_FFFF;
    applyStimulus(10'h300, 4, 0, 0, 0, -1, 0);
    checkOutput("checksum_word", lastWdata, 32'h0000_0005);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
